key_event_scheduler: RTL and testbench
======================================

# key_event_scheduler

Sits between the PS/2 keyboard receiver and the Pong game state machine. It parses raw scan-code bytes (make, break `F0`, extended `E0`) into game commands. It tracks which game keys are held and buffers first-press commands in a small FIFO. It issues at most one command per video frame to the game FSM over a valid/ready handshake, and generates paddle auto-repeat while a paddle key stays held.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, 2..16.
- `REPEAT_FRAMES`, 2: frames between auto-repeat commands for a held paddle key; 1..63.

Ports:
- `clock` in 1: system/pixel clock.
- `reset` in 1: asynchronous, active-high reset.
- `rx_data` in 8: last scan-code byte from the PS/2 receiver.
- `rx_done` in 1: receiver done level; a rising edge marks a new valid `rx_data`.
- `frame_start` in 1: one-cycle pulse per video frame.
- `cmd_ready` in 1: game FSM accepts `cmd_code`.
- `cmd_valid` out 1: a command is presented.
- `cmd_code` out 4: command code, from the package enum.
- `held` out 8: held-key bitmap; bit order is CMD code minus 1.
- `overflow` out 1: sticky flag; set when a FIFO push was dropped.

## Operation
- Commands: NONE=0, P1_LEFT=1 (`1C`), P1_RIGHT=2 (`23`), P2_LEFT=3 (`3B`), P2_RIGHT=4 (`4B`), SPACE=5 (`29`), ESC=6 (`76`), KEY1=7 (`16`), KEY2=8 (`1E`). Every other code is unmapped.
- Byte strobe: `done_q` registers `rx_done`. A byte is taken on a cycle where `rx_done & ~done_q` is true.
- Parser FSM states are IDLE, BRK, EXT and EXT_BRK. Transitions per byte:
  - IDLE: `F0` goes to BRK; `E0` goes to EXT; anything else is a make and stays in IDLE.
  - BRK: the byte is a break code; go to IDLE.
  - EXT: `F0` goes to EXT_BRK; anything else goes to IDLE with no effect.
  - EXT_BRK: any byte goes to IDLE with no effect. Extended keys are never mapped.
- Make of a mapped key whose `held` bit is 0: set the `held` bit and push the command into the FIFO.
- Make of a key already held (typematic repeat): no effect.
- Unmapped make: no effect.
- Break of a mapped key: clear its `held` bit; no FIFO push. Break of an unheld or unmapped key: no effect.
- Issue: on `frame_start` with `cmd_valid`=0:
  - If the FIFO is non-empty, pop the head into `cmd_code`.
  - Otherwise, if `rep_cnt`==`REPEAT_FRAMES`-1 and any of `held[3:0]` is set, issue the next held paddle key at or after the round-robin pointer `rr`, then set `rr` to the issued index+1 (mod 4).
  - Otherwise issue nothing.
- `rep_cnt` counts `frame_start` pulses from 0 to `REPEAT_FRAMES`-1, wraps, and resets to 0 whenever `held[3:0]` becomes all zero.
- `frame_start` while `cmd_valid`=1 is ignored; there is no queueing of frames. `rep_cnt` still advances.
- FIFO full with a push: the command is dropped and `overflow` is set to 1. Only `reset` clears `overflow`.
- Push and pop in the same cycle are always legal, including when the FIFO is full. The pop frees the slot and the push is accepted, so the count is unchanged.
- `reset` asserted mid-operation: everything returns to reset values immediately. A partially parsed `F0`/`E0` sequence is discarded.

## Timing
- Reset values:
  - Outputs: `cmd_valid`=0, `cmd_code`=0, `held`=0, `overflow`=0.
  - Internal: parser IDLE, FIFO empty, `rep_cnt`=0, `rr`=0, `done_q`=0.
- Byte taken at edge N: `held` and the FIFO count update at N+1.
- Issue at the `frame_start` cycle F: `cmd_valid`=1 and `cmd_code` valid from F+1. The FIFO pop also happens at F.
- Transfer: a rising edge with `cmd_valid`&`cmd_ready` completes it, and `cmd_valid`=0 on the next cycle. `cmd_code` stays stable while `cmd_valid`=1.
- A `frame_start` in the same cycle as a transfer is ignored, because `cmd_valid` is still 1 in that cycle.
- Latency from a key byte to command presentation is at most one frame plus 1 cycle when the FIFO is empty.

## Structure
- Package `pong_keys_pkg`: scan-code constants (`F0`, `E0` and the eight keys), the 4-bit command enum, and a scan-to-command mapping function.
- Sub-module `key_fifo`:
  - Parameterised by `DEPTH` and `WIDTH`=4.
  - Ports: push, pop, din, dout, full, empty.
  - Uses the same `clock`/`reset` as the parent.
- The top level holds the parser FSM, the `held` register, `rep_cnt`, `rr` and the issue/handshake logic.

## Test plan
- Reset check: drive bytes `29`, `F0`, `29` with `cmd_ready`=1, then pulse `frame_start` → `cmd_code`=5 for one cycle; `held[4]` rises and then clears.
- Typematic: `1C` sent three times, then `frame_start`×6 with `REPEAT_FRAMES`=2 → one FIFO command 1, then repeat command 1 on every second frame; `F0 1C` stops the repeats.
- Round-robin: hold `1C` and `4B` with the FIFO empty → repeat commands alternate 1, 4, 1, 4.
- Overflow: with `FIFO_DEPTH`=4 and no `frame_start`, make keys `29`, `76`, `16`, `1E` and `1C` → `overflow`=1; the next four issues are 5, 6, 7, 8 and the `1C` command is lost.
- Extended keys and backpressure: `E0 75`, then `E0 F0 75` → no command and `held`=0. With `cmd_ready`=0, `cmd_valid` stays high with a stable code across 3 `frame_start` pulses.
- Mid-sequence reset: assert `reset` after `F0` → after release, a byte `29` acts as a make (`held[4]`=1).

Source files
------------

// File: rtl/pong_keys_pkg.sv
// Shared scan-code constants, command encoding and parser states for the
// PS/2-to-Pong key event path.
package pong_keys_pkg;

   // Scan-code prefixes
   localparam logic [7:0] SC_BREAK    = 8'hF0;
   localparam logic [7:0] SC_EXT      = 8'hE0;

   // Game key make codes (set 2)
   localparam logic [7:0] SC_P1_LEFT  = 8'h1C;
   localparam logic [7:0] SC_P1_RIGHT = 8'h23;
   localparam logic [7:0] SC_P2_LEFT  = 8'h3B;
   localparam logic [7:0] SC_P2_RIGHT = 8'h4B;
   localparam logic [7:0] SC_SPACE    = 8'h29;
   localparam logic [7:0] SC_ESC      = 8'h76;
   localparam logic [7:0] SC_KEY1     = 8'h16;
   localparam logic [7:0] SC_KEY2     = 8'h1E;

   localparam int unsigned NUM_KEYS   = 8;
   localparam int unsigned NUM_PADDLE = 4;
   localparam int unsigned CMD_W      = 4;

   // Codes 1..4 are the paddle keys; held-bit index is code minus 1
   typedef enum logic [3:0] {
      CMD_NONE     = 4'd0,
      CMD_P1_LEFT  = 4'd1,
      CMD_P1_RIGHT = 4'd2,
      CMD_P2_LEFT  = 4'd3,
      CMD_P2_RIGHT = 4'd4,
      CMD_SPACE    = 4'd5,
      CMD_ESC      = 4'd6,
      CMD_KEY1     = 4'd7,
      CMD_KEY2     = 4'd8
   } cmd_t;

   typedef enum logic [1:0] {
      PS_IDLE,
      PS_BRK,
      PS_EXT,
      PS_EXT_BRK
   } parse_state_t;

   // Translate a non-extended scan code to a game command (NONE if unmapped)
   function automatic cmd_t scan_to_cmd(input logic [7:0] sc);
      cmd_t c;
      case (sc)
         SC_P1_LEFT:  c = CMD_P1_LEFT;
         SC_P1_RIGHT: c = CMD_P1_RIGHT;
         SC_P2_LEFT:  c = CMD_P2_LEFT;
         SC_P2_RIGHT: c = CMD_P2_RIGHT;
         SC_SPACE:    c = CMD_SPACE;
         SC_ESC:      c = CMD_ESC;
         SC_KEY1:     c = CMD_KEY1;
         SC_KEY2:     c = CMD_KEY2;
         default:     c = CMD_NONE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/key_event_scheduler_fifo.sv
// Small synchronous FIFO for first-press commands. Head is shown
// combinationally on dout. A push while full is accepted only when a pop
// frees a slot in the same cycle; the caller detects dropped pushes.
module key_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // Storage array: written on accepted pushes only
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/key_event_scheduler.sv
// Parses PS/2 scan-code bytes into Pong commands, tracks held keys, queues
// first presses and issues at most one command per frame to the game FSM,
// with round-robin auto-repeat of held paddle keys.
module key_event_scheduler
   import pong_keys_pkg::*;
#(
   parameter int FIFO_DEPTH    = 4,
   parameter int REPEAT_FRAMES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   input  logic       frame_start,
   input  logic       cmd_ready,
   output logic       cmd_valid,
   output logic [3:0] cmd_code,
   output logic [7:0] held,
   output logic       overflow
);

   localparam logic [5:0] REP_LAST = 6'(REPEAT_FRAMES - 1);

   parse_state_t state;
   parse_state_t state_nxt;

   logic       done_q;
   logic       byte_stb;
   logic       make_ev;
   logic       brk_ev;
   cmd_t       key_cmd;
   logic       key_mapped;
   logic [2:0] key_idx;
   logic [7:0] held_nxt;
   logic       push;

   logic [3:0] fifo_dout;
   logic       fifo_full;
   logic       fifo_empty;

   logic       issue_en;
   logic       pop;
   logic       rep_issue;
   logic [5:0] rep_cnt;
   logic [1:0] rr;
   logic [1:0] rr_idx;
   logic       rr_found;
   logic [1:0] cand;
   cmd_t       cmd_reg;

   assign byte_stb   = rx_done & ~done_q;
   assign key_cmd    = scan_to_cmd(rx_data);
   assign key_mapped = (key_cmd != CMD_NONE);
   assign key_idx    = 3'(key_cmd - 4'd1);
   assign cmd_code   = cmd_reg;

   // Receiver done level delayed one cycle for rising-edge detection
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         done_q <= 1'b0;
      end else begin
         done_q <= rx_done;
      end
   end

   // Parser state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= PS_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Parser next state; flags plain makes and breaks, extended keys do nothing
   always_comb begin
      state_nxt = state;
      make_ev   = 1'b0;
      brk_ev    = 1'b0;
      if (byte_stb) begin
         case (state)
            PS_IDLE: begin
               if (rx_data == SC_BREAK) begin
                  state_nxt = PS_BRK;
               end else if (rx_data == SC_EXT) begin
                  state_nxt = PS_EXT;
               end else begin
                  make_ev = 1'b1;
               end
            end
            PS_BRK: begin
               brk_ev    = 1'b1;
               state_nxt = PS_IDLE;
            end
            PS_EXT: begin
               state_nxt = (rx_data == SC_BREAK) ? PS_EXT_BRK : PS_IDLE;
            end
            PS_EXT_BRK: begin
               state_nxt = PS_IDLE;
            end
            default: begin
               state_nxt = PS_IDLE;
            end
         endcase
      end
   end

   // Held bitmap update; only a fresh press of a mapped key enters the FIFO
   always_comb begin
      held_nxt = held;
      push     = 1'b0;
      if (make_ev && key_mapped && !held[key_idx]) begin
         held_nxt[key_idx] = 1'b1;
         push              = 1'b1;
      end
      if (brk_ev && key_mapped) begin
         held_nxt[key_idx] = 1'b0;
      end
   end

   // Held register and sticky overflow on a dropped push
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         held     <= '0;
         overflow <= 1'b0;
      end else begin
         held <= held_nxt;
         if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

   key_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (4'(key_cmd)),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Issue decision: queued first presses win over auto-repeat; repeat scans
   // the paddle bits starting at rr so simultaneously held keys alternate
   always_comb begin
      issue_en  = frame_start & ~cmd_valid;
      pop       = issue_en & ~fifo_empty;
      rr_found  = 1'b0;
      rr_idx    = rr;
      cand      = rr;
      for (int unsigned k = 0; k < NUM_PADDLE; k++) begin
         cand = rr + 2'(k);
         if (!rr_found && held[cand]) begin
            rr_found = 1'b1;
            rr_idx   = cand;
         end
      end
      rep_issue = issue_en & fifo_empty & rr_found & (rep_cnt == REP_LAST);
   end

   // Frame counter for auto-repeat; parked at zero while no paddle is held
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rep_cnt <= '0;
      end else if (held_nxt[3:0] == 4'b0000) begin
         rep_cnt <= '0;
      end else if (frame_start) begin
         rep_cnt <= (rep_cnt == REP_LAST) ? 6'd0 : rep_cnt + 6'd1;
      end
   end

   // Command output register and valid/ready handshake
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cmd_valid <= 1'b0;
         cmd_reg   <= CMD_NONE;
         rr        <= '0;
      end else if (pop) begin
         cmd_valid <= 1'b1;
         cmd_reg   <= cmd_t'(fifo_dout);
      end else if (rep_issue) begin
         cmd_valid <= 1'b1;
         cmd_reg   <= cmd_t'({2'b00, rr_idx} + 4'd1);
         rr        <= rr_idx + 2'd1;
      end else if (cmd_valid && cmd_ready) begin
         cmd_valid <= 1'b0;
         cmd_reg   <= CMD_NONE;
      end
   end

endmodule

// File: tb/tb_key_event_scheduler.sv
// Self-checking bench for key_event_scheduler: expected commands are queued
// when key bytes / repeat frames are driven and popped when the DUT presents.
module tb_key_event_scheduler;

   logic       clock;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       frame_start;
   logic       cmd_ready;
   logic       cmd_valid;
   logic [3:0] cmd_code;
   logic [7:0] held;
   logic       overflow;

   int unsigned checks;
   int unsigned passed;
   logic [3:0]  exp_q[$];

   key_event_scheduler #(
      .FIFO_DEPTH    (4),
      .REPEAT_FRAMES (2)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .rx_data     (rx_data),
      .rx_done     (rx_done),
      .frame_start (frame_start),
      .cmd_ready   (cmd_ready),
      .cmd_valid   (cmd_valid),
      .cmd_code    (cmd_code),
      .held        (held),
      .overflow    (overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      tick();
   endtask

   task automatic frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   // Wait (bounded) for a presented command and compare with scoreboard head
   task automatic expect_cmd(input string name);
      logic       seen;
      logic [3:0] exp;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clock);
         if (cmd_valid) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         $display("FAIL %s: cmd_valid stayed 0 for 20 cycles, required 1", name);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else if (exp_q.size() == 0) begin
         $display("FAIL %s: unexpected cmd_code=%0d, required no command", name, cmd_code);
      end else begin
         exp = exp_q.pop_front();
         if (cmd_code !== exp)
            $display("FAIL %s: cmd_code=%0d, required %0d", name, cmd_code, exp);
         else
            passed++;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic expect_none(input string name);
      logic seen;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clock);
         if (cmd_valid) seen = 1'b1;
      end
      checks++;
      if (seen)
         $display("FAIL %s: cmd_valid=1 cmd_code=%0d, required no command", name, cmd_code);
      else
         passed++;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      checks++;
      if (cmd_valid !== 1'b0) $display("FAIL rst_valid: cmd_valid=%b, required 0", cmd_valid);
      else passed++;
      checks++;
      if (cmd_code !== 4'd0) $display("FAIL rst_code: cmd_code=%0d, required 0", cmd_code);
      else passed++;
      checks++;
      if (held !== 8'h00) $display("FAIL rst_held: held=%h, required 00", held);
      else passed++;
      checks++;
      if (overflow !== 1'b0) $display("FAIL rst_ovf: overflow=%b, required 0", overflow);
      else passed++;
      reset = 1'b0;
      tick();
      cmd_ready = 1'b1;
      send_byte(8'h29);
      exp_q.push_back(4'd5);
      checks++;
      if (held !== 8'h10) $display("FAIL space_make: held=%h, required 10", held);
      else passed++;
      send_byte(8'hF0);
      send_byte(8'h29);
      checks++;
      if (held !== 8'h00) $display("FAIL space_break: held=%h, required 00", held);
      else passed++;
      frame();
      expect_cmd("space_cmd");
      @(negedge clock);
      checks++;
      if (cmd_valid !== 1'b0) $display("FAIL space_xfer: cmd_valid=%b, required 0", cmd_valid);
      else passed++;
      tick();
   endtask

   task automatic test_typematic();
      send_byte(8'h1C);
      send_byte(8'h1C);
      send_byte(8'h1C);
      checks++;
      if (held !== 8'h01) $display("FAIL typ_held: held=%h, required 01", held);
      else passed++;
      exp_q.push_back(4'd1);
      frame(); expect_cmd("typ_fifo");
      exp_q.push_back(4'd1);
      frame(); expect_cmd("typ_rep1");
      frame(); expect_none("typ_gap1");
      exp_q.push_back(4'd1);
      frame(); expect_cmd("typ_rep2");
      frame(); expect_none("typ_gap2");
      exp_q.push_back(4'd1);
      frame(); expect_cmd("typ_rep3");
      send_byte(8'hF0);
      send_byte(8'h1C);
      checks++;
      if (held !== 8'h00) $display("FAIL typ_release: held=%h, required 00", held);
      else passed++;
      frame(); expect_none("typ_stop1");
      frame(); expect_none("typ_stop2");
   endtask

   task automatic test_round_robin();
      do_reset();
      send_byte(8'h1C);
      send_byte(8'h4B);
      checks++;
      if (held !== 8'h09) $display("FAIL rr_held: held=%h, required 09", held);
      else passed++;
      exp_q.push_back(4'd1);
      frame(); expect_cmd("rr_fifo1");
      exp_q.push_back(4'd4);
      frame(); expect_cmd("rr_fifo4");
      frame(); expect_none("rr_gap1");
      exp_q.push_back(4'd1);
      frame(); expect_cmd("rr_rep1");
      frame(); expect_none("rr_gap2");
      exp_q.push_back(4'd4);
      frame(); expect_cmd("rr_rep4");
      frame(); expect_none("rr_gap3");
      exp_q.push_back(4'd1);
      frame(); expect_cmd("rr_rep1b");
      send_byte(8'hF0); send_byte(8'h1C);
      send_byte(8'hF0); send_byte(8'h4B);
   endtask

   task automatic test_overflow();
      logic [7:0] keys [5];
      keys[0] = 8'h29; keys[1] = 8'h76; keys[2] = 8'h16; keys[3] = 8'h1E; keys[4] = 8'h1C;
      do_reset();
      checks++;
      if (overflow !== 1'b0) $display("FAIL ovf_clear: overflow=%b, required 0", overflow);
      else passed++;
      for (int i = 0; i < 5; i++) send_byte(keys[i]);
      checks++;
      if (overflow !== 1'b1) $display("FAIL ovf_set: overflow=%b, required 1", overflow);
      else passed++;
      checks++;
      if (held !== 8'hF1) $display("FAIL ovf_held: held=%h, required f1", held);
      else passed++;
      for (int i = 5; i <= 8; i++) begin
         exp_q.push_back(4'(i));
         frame();
         expect_cmd("ovf_drain");
      end
      frame(); expect_none("ovf_lost");
      for (int i = 0; i < 5; i++) begin
         send_byte(8'hF0);
         send_byte(keys[i]);
      end
      checks++;
      if (held !== 8'h00 || overflow !== 1'b1)
         $display("FAIL ovf_release: held=%h overflow=%b, required 00 and 1", held, overflow);
      else passed++;
   endtask

   task automatic test_extended();
      do_reset();
      send_byte(8'hE0); send_byte(8'h75);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      send_byte(8'hE0); send_byte(8'h1C);
      checks++;
      if (held !== 8'h00) $display("FAIL ext_held: held=%h, required 00", held);
      else passed++;
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h1C);
      frame(); expect_none("ext_nocmd");
   endtask

   task automatic test_back_to_back();
      cmd_ready = 1'b0;
      send_byte(8'h29);
      exp_q.push_back(4'd5);
      frame(); expect_cmd("bp_first");
      send_byte(8'h76);
      for (int i = 0; i < 3; i++) begin
         frame();
         tick();
         checks++;
         if (cmd_valid !== 1'b1 || cmd_code !== 4'd5)
            $display("FAIL bp_hold: cmd_valid=%b cmd_code=%0d, required 1 and 5", cmd_valid, cmd_code);
         else passed++;
      end
      cmd_ready = 1'b1;
      tick();
      checks++;
      if (cmd_valid !== 1'b0) $display("FAIL bp_release: cmd_valid=%b, required 0", cmd_valid);
      else passed++;
      exp_q.push_back(4'd6);
      frame(); expect_cmd("bp_next");
      send_byte(8'hF0); send_byte(8'h29);
      send_byte(8'hF0); send_byte(8'h76);
      checks++;
      if (held !== 8'h00) $display("FAIL bp_held: held=%h, required 00", held);
      else passed++;
   endtask

   task automatic test_mid_reset();
      send_byte(8'hF0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      send_byte(8'h29);
      checks++;
      if (held !== 8'h10) $display("FAIL midrst_make: held=%h, required 10", held);
      else passed++;
      exp_q.push_back(4'd5);
      frame(); expect_cmd("midrst_cmd");
      checks++;
      if (exp_q.size() != 0) $display("FAIL sb_empty: %0d entries left, required 0", exp_q.size());
      else passed++;
   endtask

   initial begin
      checks      = 0;
      passed      = 0;
      reset       = 1'b1;
      rx_data     = 8'h00;
      rx_done     = 1'b0;
      frame_start = 1'b0;
      cmd_ready   = 1'b0;
      test_reset();
      test_typematic();
      test_round_robin();
      test_overflow();
      test_extended();
      test_back_to_back();
      test_mid_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
